bit_serializer: RTL and testbench

- Parallel-to-serial front end that feeds the single-bit input `a` of the pattern-detector FSMs (patternMoore and kin).
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock, MSB-first by default.
- Supports gapless back-to-back frames.
- Marks frame boundaries and keeps a wrap-around count of completed frames for the detector benches.

---
 rtl/bit_serializer.sv | 107 ++++++++++
 tb/tb_bit_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one bit per clock out on `a`.
// Latency: first bit on `a` the cycle after the accepting edge; back-to-back frames are gapless.
// Backpressure: in_ready is high only when idle or on the last bit of the current frame.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a,
  output logic             a_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic          IDLE_BIT = 1'(IDLE_LEVEL);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_nxt;
  logic             last_bit;
  logic             accept;
  logic             bit_nxt;

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
  assign accept   = in_valid && in_ready;

  // State register, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next state: a word accepted on the last bit keeps us in SHIFT with no gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next datapath: load on accept, otherwise shift the outgoing bit away.
  always_comb begin
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    if (accept) begin
      sreg_nxt    = in_data;
      bit_cnt_nxt = '0;
    end else if ((state == SHIFT) && !last_bit) begin
      if (MSB_FIRST != 0) sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
      else                sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
      bit_cnt_nxt = bit_cnt + 1'b1;
    end
  end

  // Outputs: handshake/status decode plus the bit that goes out next cycle.
  always_comb begin
    in_ready = reset && ((state == IDLE) || last_bit);
    busy     = (state == SHIFT);
    bit_nxt  = (MSB_FIRST != 0) ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
  end

  // Registered serial outputs follow the next state so they line up with bit_cnt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a           <= IDLE_BIT;
      a_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      a           <= (state_nxt == SHIFT) ? bit_nxt : IDLE_BIT;
      a_valid     <= (state_nxt == SHIFT);
      frame_start <= (state_nxt == SHIFT) && (bit_cnt_nxt == '0);
      frame_done  <= (state_nxt == SHIFT) && (bit_cnt_nxt == LAST);
    end
  end

  // Completed-frame counter, bumped at the end of every last-bit cycle.
  always_ff @(posedge clk) begin
    if (!reset) frame_count <= '0;
    else if (last_bit) frame_count <= frame_count + 1'b1;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances share one stimulus stream.
// u_msb is the default configuration, u_lsb sends LSB first, u_cnt has a 2-bit frame counter.
// Expected bits are queued at each accept and popped as the DUT emits them.
module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;

  logic        rdy0, a0, av0, fs0, fd0, busy0;
  logic [15:0] fc0;
  logic        rdy1, a1, av1, fs1, fd1, busy1;
  logic [15:0] fc1;
  logic        rdy2, a2, av2, fs2, fd2, busy2;
  logic [1:0]  fc2;

  exp_t q0[$];
  exp_t q1[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_busy  = 1'b0;
  int   m_cnt   = 0;
  int   m_frames = 0;
  logic last_acc = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0), .CNT_W(16)) u_msb (
    .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .a(a0), .a_valid(av0), .frame_start(fs0), .frame_done(fd0), .busy(busy0), .frame_count(fc0));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0), .CNT_W(16)) u_lsb (
    .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .a(a1), .a_valid(av1), .frame_start(fs1), .frame_done(fd1), .busy(busy1), .frame_count(fc1));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0), .CNT_W(2)) u_cnt (
    .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
    .a(a2), .a_valid(av2), .frame_start(fs2), .frame_done(fd2), .busy(busy2), .frame_count(fc2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop one scoreboard entry when the DUT shows a valid bit, else expect idle outputs.
  task automatic check_stream(input string tag, input logic av, input logic a, input logic fs,
                              input logic fd, inout exp_t q[$]);
    exp_t e;
    chk({tag, "_a_valid"}, 16'(av), 16'(m_busy));
    if (av === 1'b1) begin
      if (q.size() == 0) begin
        chk({tag, "_unexpected_bit"}, 16'(q.size()), 16'd1);
      end else begin
        e = q.pop_front();
        chk({tag, "_a"}, 16'(a), 16'(e.b));
        chk({tag, "_frame_start"}, 16'(fs), 16'(e.s));
        chk({tag, "_frame_done"}, 16'(fd), 16'(e.d));
      end
    end else begin
      chk({tag, "_idle_a"}, 16'(a), 16'd0);
      chk({tag, "_idle_start"}, 16'(fs), 16'd0);
      chk({tag, "_idle_done"}, 16'(fd), 16'd0);
    end
  endtask

  // One clock: check ready before the edge, update the model at the edge, check outputs after.
  task automatic tick();
    logic exp_rdy;
    logic last;
    exp_t e;
    #1;
    exp_rdy = rst_n && (!m_busy || (m_cnt == 7));
    chk("in_ready_msb", 16'(rdy0), 16'(exp_rdy));
    chk("in_ready_lsb", 16'(rdy1), 16'(exp_rdy));
    chk("in_ready_cnt", 16'(rdy2), 16'(exp_rdy));
    last     = m_busy && (m_cnt == 7);
    last_acc = in_valid && exp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_frames = 0;
      q0.delete();
      q1.delete();
    end else begin
      if (last) m_frames++;
      if (last_acc) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
          e.s = (i == 0);
          e.d = (i == 7);
          e.b = in_data[7-i];
          q0.push_back(e);
          e.b = in_data[i];
          q1.push_back(e);
        end
      end else if (last) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_cnt++;
      end
    end
    #1;
    check_stream("msb", av0, a0, fs0, fd0, q0);
    check_stream("lsb", av1, a1, fs1, fd1, q1);
    chk("busy_msb", 16'(busy0), 16'(m_busy));
    chk("frame_count_msb", fc0, 16'(m_frames));
    chk("frame_count_wrap", 16'(fc2), 16'(m_frames % 4));
  endtask

  // Offer a word and hold it until accepted, bounded.
  task automatic send(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 32);
    if (!last_acc) chk("send_timeout", 16'(n), 16'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with a word offered: nothing may be accepted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    idle(2);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(1);

    // Abort a frame after three bits, then release reset.
    send(8'hFF);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    chk("abort_busy", 16'(busy0), 16'd0);
    chk("abort_count", fc0, 16'd0);
    rst_n = 1'b1;
    idle(1);

    // Single frame 0101_0110.
    send(8'b0101_0110);
    idle(9);
    chk("single_count", fc0, 16'd1);

    // Gapless back-to-back frames.
    send(8'hA5);
    send(8'h3C);
    idle(9);
    chk("b2b_count", fc0, 16'd3);

    // 8'h01: MSB instance sends 0000_0001, LSB instance sends 1000_0000.
    send(8'h01);
    idle(9);

    // Word offered mid-frame must be ignored.
    send(8'hC3);
    idle(2);
    in_valid = 1'b1;
    in_data  = 8'h00;
    idle(1);
    in_valid = 1'b0;
    idle(8);

    chk("final_count", fc0, 16'd5);
    chk("final_count_wrap", 16'(fc2), 16'd1);
    chk("queue_msb_empty", 16'(q0.size()), 16'd0);
    chk("queue_lsb_empty", 16'(q1.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
